parity_rx_check: RTL and testbench
==================================

// Module: parity_rx_check
// PURPOSE
//  Serial receive-side parity checker; the checking end of the XOR parity generator cells.
//  Accepts a serial frame of DATA_W data bits, LSB first, followed by one parity bit.
//  Deserialises the data bits and keeps a running XOR. Presents the parallel word, a parity-error flag
//  and a saturating error count to downstream logic.
// PARAMETERS
//  DATA_W      8   data bits per frame (2..32)
//  PARITY_ODD  0   0 = even parity (XOR of data+parity == 0), 1 = odd parity (== 1)
//  CNT_W       8   width of saturating error counter ERRCNT
// PORTS
//  CP      in   1        clock, all state changes on rising edge
//  RST     in   1        synchronous reset, active high
//  SI      in   1        serial bit in
//  SV      in   1        SI valid qualifier; a bit is consumed only when SV=1
//  ABORT   in   1        discard partial frame, return to IDLE
//  DOUT    out  DATA_W   last completed data word
//  DV      out  1        one-cycle pulse: DOUT/PERR updated this cycle
//  PERR    out  1        parity error of last completed frame
//  BUSY    out  1        frame in progress (state != IDLE)
//  ERRCNT  out  CNT_W    count of frames with PERR=1, saturates at all-ones
// BEHAVIOUR
//  Reset (RST=1 at edge): state=IDLE, bit counter=0, shift reg=0, running parity=0, DOUT=0,
//   DV=0, PERR=0, BUSY=0, ERRCNT=0. RST overrides all other inputs, including mid-frame.
//  States:
//   IDLE: SV=1 -> bit0 loaded, parity p=SI, cnt=1 -> SHIFT (or PARITY if DATA_W==1 unused).
//   SHIFT: each SV=1 shifts SI into bit[cnt], p^=SI, cnt++. When cnt reaches DATA_W -> PARITY.
//   PARITY: SV=1 -> frame complete, return to IDLE. SV=0 cycles hold state.
//  Completion (parity bit accepted at edge N): at the same edge N,
//   DOUT<=assembled word, PERR<=p^SI^PARITY_ODD, DV<=1 (high for the cycle after edge N only).
//   ERRCNT<=ERRCNT+1 if the new PERR=1 and ERRCNT != all-ones.
//  Latency: DV asserts 1 cycle after the parity bit's SV cycle; total DATA_W+1 valid bits per frame.
//  Output hold: DOUT/PERR hold between completions; DV=0 otherwise; no back-pressure.
//  Back-to-back: a new frame's first bit can be accepted the cycle DV=1 (IDLE reached at edge N).
//  SV=0 gaps: tolerated anywhere in a frame, unlimited length; no timeout.
//  ABORT=1 (not reset): next state IDLE, cnt=0, p=0. The concurrent SI/SV bit is dropped.
//   DOUT/PERR/ERRCNT are unchanged and there is no DV. ABORT in IDLE is a no-op.
//  ABORT in PARITY with SV=1: abort wins, no completion.
//  BUSY = (state != IDLE), registered with the state.
//  Counter width: cnt is $clog2(DATA_W+1) bits; no wrap (state leaves SHIFT at DATA_W).
//  X on SI while SV=0 must not affect any state.
// TESTING  (DATA_W=8, PARITY_ODD=0, CNT_W=2 unless noted)
//  1 Good frame: SV=1 continuous, bits 1,0,1,0,0,1,0,1 then parity 0 -> next cycle DV=1,
//    DOUT=8'hA5, PERR=0, ERRCNT=0; BUSY high 8 cycles from first bit edge.
//  2 Bad parity: same data, parity 1 -> DV=1, DOUT=8'hA5, PERR=1, ERRCNT=1.
//  3 Gaps + back-to-back: 0x3C sent with SV=0 gaps of 3 cycles, then 0xFF+0 starting the DV cycle
//    -> two DV pulses, DOUT=8'h3C then 8'hFF, PERR=0 both.
//  4 Saturation: 5 consecutive bad-parity frames -> ERRCNT 1,2,3,3,3; PERR=1 each.
//  5 Abort/reset mid-frame: ABORT after 5 bits, then full 0x5A frame -> single DV, DOUT=8'h5A.
//    Then RST after 3 bits -> all outputs 0 next cycle, BUSY=0.
//  6 Odd parity (PARITY_ODD=1): 0x00 with parity 1 -> PERR=0; with parity 0 -> PERR=1.

Source files
------------

// File: rtl/parity_rx_check.sv
// Serial receive-side parity checker. Deserialises DATA_W bits, LSB first, then checks one parity bit.
// Presents the word, a parity-error flag and a saturating error count.
module parity_rx_check #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input  logic              CP,
    input  logic              RST,
    input  logic              SI,
    input  logic              SV,
    input  logic              ABORT,
    output logic [DATA_W-1:0] DOUT,
    output logic              DV,
    output logic              PERR,
    output logic              BUSY,
    output logic [CNT_W-1:0]  ERRCNT
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] WORD_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  ERR_MAX   = {CNT_W{1'b1}};
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DATA_W - 1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic              par_r, par_s;
    logic [DATA_W-1:0] dout_s;
    logic              dv_s, perr_s, busy_s;
    logic [CNT_W-1:0]  errcnt_s;

    // Frame error: running data parity XOR parity bit, offset by the selected sense.
    function automatic logic frame_err(input logic run_par, input logic par_bit, input logic odd);
        return run_par ^ par_bit ^ odd;
    endfunction

    // Next-state and next-output logic; SI is only looked at when SV qualifies it.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shift_s  = shift_r;
        par_s    = par_r;
        dout_s   = DOUT;
        perr_s   = PERR;
        dv_s     = 1'b0;
        errcnt_s = ERRCNT;
        if (ABORT) begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
            par_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (SV) begin
                        shift_s = SI ? WORD_ONE : WORD_ZERO;
                        par_s   = SI;
                        cnt_s   = CW'(1);
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (SV) begin
                        shift_s = SI ? (shift_r | (WORD_ONE << cnt_r)) : shift_r;
                        par_s   = par_r ^ SI;
                        cnt_s   = cnt_r + CW'(1);
                        if (cnt_r == CNT_LAST) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_SHIFT;
                        end
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
                ST_PARITY: begin
                    if (SV) begin
                        dout_s  = shift_r;
                        perr_s  = frame_err(par_r, SI, ODD_BIT);
                        dv_s    = 1'b1;
                        state_s = ST_IDLE;
                        cnt_s   = {CW{1'b0}};
                        par_s   = 1'b0;
                        if (perr_s && (ERRCNT != ERR_MAX)) begin
                            errcnt_s = ERRCNT + CNT_W'(1);
                        end else begin
                            errcnt_s = ERRCNT;
                        end
                    end else begin
                        state_s = ST_PARITY;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                    par_s   = 1'b0;
                end
            endcase
        end
        busy_s = (state_s != ST_IDLE);
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge CP) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge CP) begin
        if (RST) begin
            cnt_r   <= {CW{1'b0}};
            shift_r <= WORD_ZERO;
            par_r   <= 1'b0;
            DOUT    <= WORD_ZERO;
            DV      <= 1'b0;
            PERR    <= 1'b0;
            BUSY    <= 1'b0;
            ERRCNT  <= {CNT_W{1'b0}};
        end else begin
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            DOUT    <= dout_s;
            DV      <= dv_s;
            PERR    <= perr_s;
            BUSY    <= busy_s;
            ERRCNT  <= errcnt_s;
        end
    end

endmodule

// File: tb/tb_parity_rx_check.sv
// Bench for parity_rx_check: an even-parity and an odd-parity instance share one serial stream;
// expected frames are queued at stimulus time and a negedge monitor checks every DV pulse.
module tb_parity_rx_check;

    logic       CP = 1'b0;
    logic       RST, SI, SV, ABORT;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, perr_e, perr_o, busy_e, busy_o;
    logic [1:0] errcnt_e, errcnt_o;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic [1:0] cnt;
        int         at;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   model_cnt_e = 0;
    int   model_cnt_o = 0;
    bit   mon_en = 1'b0;

    parity_rx_check #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(2)) dut_even (
        .CP(CP), .RST(RST), .SI(SI), .SV(SV), .ABORT(ABORT),
        .DOUT(dout_e), .DV(dv_e), .PERR(perr_e), .BUSY(busy_e), .ERRCNT(errcnt_e));

    parity_rx_check #(.DATA_W(8), .PARITY_ODD(1), .CNT_W(2)) dut_odd (
        .CP(CP), .RST(RST), .SI(SI), .SV(SV), .ABORT(ABORT),
        .DOUT(dout_o), .DV(dv_o), .PERR(perr_o), .BUSY(busy_o), .ERRCNT(errcnt_o));

    always #5 CP = ~CP;

    always @(posedge CP) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DV pulse must match the oldest queued frame and arrive on its cycle.
    always @(negedge CP) begin
        exp_t e;
        if (mon_en) begin
            if (dv_e) begin
                if (q_e.size() == 0) begin
                    check("even_dv_spurious", dv_e, 1'b0);
                end else begin
                    e = q_e.pop_front();
                    check("even_dout", dout_e, e.d);
                    check("even_perr", perr_e, e.perr);
                    check("even_errcnt", errcnt_e, e.cnt);
                    check("even_dv_cycle", cyc, e.at);
                end
            end else if (q_e.size() > 0 && q_e[0].at <= cyc) begin
                check("even_dv_missing", dv_e, 1'b1);
                void'(q_e.pop_front());
            end
            if (dv_o) begin
                if (q_o.size() == 0) begin
                    check("odd_dv_spurious", dv_o, 1'b0);
                end else begin
                    e = q_o.pop_front();
                    check("odd_dout", dout_o, e.d);
                    check("odd_perr", perr_o, e.perr);
                    check("odd_errcnt", errcnt_o, e.cnt);
                    check("odd_dv_cycle", cyc, e.at);
                end
            end else if (q_o.size() > 0 && q_o[0].at <= cyc) begin
                check("odd_dv_missing", dv_o, 1'b1);
                void'(q_o.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic check_busy(input string name, input bit exp);
        check({"even_", name}, busy_e, exp);
        check({"odd_", name}, busy_o, exp);
    endtask

    // One qualified bit, preceded by an idle gap during which SI carries noise.
    task automatic put_bit(input logic b, input int gap_lo, input int gap_hi, input int idx);
        int gaps;
        gaps = $urandom_range(gap_hi, gap_lo);
        for (int g = 0; g < gaps; g++) begin
            SV = 1'b0;
            SI = 1'($urandom);
            tick();
            check_busy("busy_gap", idx > 0);
        end
        SV = 1'b1;
        SI = b;
        tick();
        SV = 1'b0;
        SI = 1'($urandom);
        check_busy("busy_bit", idx < 8);
    endtask

    // abort_at: -1 for a complete frame, k to abort in place of bit k (8 = the parity bit).
    task automatic send_frame(input logic [7:0] d, input logic p, input int gap_lo,
                              input int gap_hi, input int abort_at);
        exp_t e;
        bit   raw;
        for (int i = 0; i <= 8; i++) begin
            if (abort_at == i) begin
                ABORT = 1'b1;
                SV    = (i == 8) ? 1'b1 : 1'($urandom);
                SI    = 1'($urandom);
                tick();
                ABORT = 1'b0;
                SV    = 1'b0;
                check_busy("busy_abort", 1'b0);
                return;
            end
            put_bit((i == 8) ? p : d[i], gap_lo, gap_hi, i);
        end
        raw = ^{d, p};
        if (raw && model_cnt_e < 3) model_cnt_e++;
        if (!raw && model_cnt_o < 3) model_cnt_o++;
        e.d = d; e.at = cyc;
        e.perr = raw;   e.cnt = 2'(model_cnt_e); q_e.push_back(e);
        e.perr = !raw;  e.cnt = 2'(model_cnt_o); q_o.push_back(e);
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_cnt_e = 0;
        model_cnt_o = 0;
        check("rst_dout", {dout_e, dout_o}, 16'h0000);
        check("rst_dv_perr", {dv_e, dv_o, perr_e, perr_o}, 4'b0000);
        check_busy("rst_busy", 1'b0);
        check("rst_errcnt", {errcnt_e, errcnt_o}, 4'b0000);
    endtask

    initial begin
        logic [7:0] d;
        RST = 1'b1; SI = 1'b0; SV = 1'b0; ABORT = 1'b0;
        tick();
        reset_dut();
        mon_en = 1'b1;

        send_frame(8'hA5, 1'b0, 0, 0, -1);      // good frame
        send_frame(8'hA5, 1'b1, 0, 0, -1);      // bad parity
        send_frame(8'h3C, 1'b0, 3, 3, -1);      // gaps, then back-to-back
        send_frame(8'hFF, 1'b0, 0, 0, -1);
        tick();
        reset_dut();
        for (int k = 0; k < 5; k++) begin       // error counter saturation
            d = 8'($urandom);
            send_frame(d, ~(^d), 0, 1, -1);
        end
        send_frame(8'($urandom), 1'b0, 0, 0, 5); // abort after 5 bits
        send_frame(8'h5A, 1'b0, 0, 0, -1);
        send_frame(8'h00, 1'b1, 0, 0, -1);      // odd-parity cases
        send_frame(8'h00, 1'b0, 0, 0, -1);
        send_frame(8'hC3, 1'b1, 0, 0, 8);       // abort wins over parity bit
        ABORT = 1'b1; SV = 1'b1; SI = 1'b1;     // abort in IDLE is a no-op
        tick();
        ABORT = 1'b0; SV = 1'b0;
        check_busy("busy_idle_abort", 1'b0);
        tick();
        for (int i = 0; i < 3; i++) put_bit(1'($urandom), 0, 1, i);
        reset_dut();                            // reset mid-frame

        for (int k = 0; k < 150; k++) begin
            int ab;
            ab = ($urandom_range(9, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
            send_frame(8'($urandom), 1'($urandom), 0, 3, ab);
            if ($urandom_range(15, 0) == 0) reset_dut();
        end

        repeat (4) tick();
        check("even_queue_drained", q_e.size(), 0);
        check("odd_queue_drained", q_o.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
